// File: rtl/spi_slave_apb4_burst_master.sv
// APB4 burst master for the SPI-slave bridge: one base address plus a word stream becomes an
// incrementing or wrapping APB burst. Optional access timeout enabled by SPI_SLAVE_APB_TIMEOUT_EN.
module spi_slave_apb4_burst_master #(
  parameter int unsigned APB_ADDR_WIDTH = 32,
  parameter int unsigned APB_DATA_WIDTH = 32,
  parameter logic [2:0]  APB_PPROT      = 3'b000,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                        apb_pclk_i,
  input  logic                        apb_preset_ni,
  input  logic                        cs_n_i,
  input  logic [APB_ADDR_WIDTH-1:0]   addr_i,
  input  logic                        addr_valid_i,
  input  logic                        rd_wr_i,
  input  logic [15:0]                 wrap_length_i,
  input  logic [APB_DATA_WIDTH-1:0]   rx_data_i,
  input  logic                        rx_valid_i,
  output logic                        rx_ready_o,
  output logic [APB_DATA_WIDTH-1:0]   tx_data_o,
  output logic                        tx_valid_o,
  input  logic                        tx_ready_i,
  output logic                        apb_psel_o,
  output logic                        apb_penable_o,
  output logic                        apb_pwrite_o,
  output logic [APB_ADDR_WIDTH-1:0]   apb_paddr_o,
  output logic [APB_DATA_WIDTH-1:0]   apb_pwdata_o,
  output logic [APB_DATA_WIDTH/8-1:0] apb_pstrb_o,
  output logic [2:0]                  apb_pprot_o,
  input  logic [APB_DATA_WIDTH-1:0]   apb_prdata_i,
  input  logic                        apb_pready_i,
  input  logic                        apb_pslverr_i,
  output logic                        busy_o,
  output logic                        err_o,
  output logic [APB_ADDR_WIDTH-1:0]   err_addr_o,
  output logic                        timeout_o,
  output logic [15:0]                 xfer_count_o
);

  localparam int unsigned BYTES = APB_DATA_WIDTH / 8;

  if (APB_DATA_WIDTH != 32 && APB_DATA_WIDTH != 64) begin : g_bad_width
    $error("APB_DATA_WIDTH must be 32 or 64");
  end
  if (TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must fit the 16-bit access counter");
  end

  typedef enum logic [1:0] {StIdle, StArm, StSetup, StAccess} state_e;

  state_e                      r_state, w_state_next;
  logic [APB_ADDR_WIDTH-1:0]   r_base, r_addr, r_err_addr;
  logic [APB_DATA_WIDTH-1:0]   r_pwdata, r_tx_data;
  logic [15:0]                 r_wrap, r_idx, r_count;
  logic                        r_rd, r_tx_valid, r_err;
  logic                        w_start, w_rx_ready, w_done, w_err, w_tout, w_psel, w_wrap_end;
  logic [APB_ADDR_WIDTH-1:0]   w_addr_inc;

  assign w_start = (r_state == StIdle) && addr_valid_i && !cs_n_i;
  assign w_done  = (r_state == StAccess) && (apb_pready_i || w_tout);
  assign w_err   = w_done && ((apb_pready_i && apb_pslverr_i) || w_tout);

`ifdef SPI_SLAVE_APB_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] r_tcnt;
  logic        r_timeout;

  // r_tcnt holds the number of ACCESS cycles already spent on this transfer
  assign w_tout = (r_state == StAccess) && !apb_pready_i && (r_tcnt == TO_LAST);

  always_ff @(posedge apb_pclk_i or negedge apb_preset_ni) begin
    if (!apb_preset_ni) begin
      r_tcnt    <= '0;
      r_timeout <= 1'b0;
    end else begin
      if (w_state_next == StSetup) begin
        r_tcnt <= '0;
      end else if (r_state == StAccess) begin
        r_tcnt <= r_tcnt + 16'd1;
      end
      if (w_start) begin
        r_timeout <= 1'b0;
      end else if (w_tout) begin
        r_timeout <= 1'b1;
      end
    end
  end

  assign timeout_o = r_timeout;
`else
  assign w_tout    = 1'b0;
  assign timeout_o = 1'b0;
`endif

  always_comb begin
    w_state_next = r_state;
    w_rx_ready   = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_start) w_state_next = StArm;
      end
      StArm: begin
        if (cs_n_i) begin
          w_state_next = StIdle;
        end else if (r_rd) begin
          if (tx_ready_i) w_state_next = StSetup;
        end else if (rx_valid_i) begin
          w_rx_ready   = 1'b1;
          w_state_next = StSetup;
        end
      end
      StSetup:  w_state_next = StAccess;
      StAccess: begin
        // A started transfer always finishes; chip select only decides where we go after it
        if (w_done) w_state_next = cs_n_i ? StIdle : StArm;
      end
      default:  w_state_next = StIdle;
    endcase
  end

  assign w_addr_inc = r_addr + APB_ADDR_WIDTH'(BYTES);
  assign w_wrap_end = (r_wrap != 16'd0) && (r_idx == r_wrap - 16'd1);

  always_ff @(posedge apb_pclk_i or negedge apb_preset_ni) begin
    if (!apb_preset_ni) begin
      r_state    <= StIdle;
      r_base     <= '0;
      r_addr     <= '0;
      r_err_addr <= '0;
      r_pwdata   <= '0;
      r_tx_data  <= '0;
      r_wrap     <= '0;
      r_idx      <= '0;
      r_count    <= '0;
      r_rd       <= 1'b0;
      r_tx_valid <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_tx_valid <= 1'b0;
      if (w_start) begin
        r_base     <= addr_i;
        r_addr     <= addr_i;
        r_rd       <= rd_wr_i;
        r_wrap     <= wrap_length_i;
        r_idx      <= '0;
        r_count    <= '0;
        r_err      <= 1'b0;
        r_err_addr <= '0;
      end
      if (w_rx_ready) r_pwdata <= rx_data_i;
      if (w_done) begin
        if (r_count != 16'hFFFF) r_count <= r_count + 16'd1;
        if (w_wrap_end) begin
          r_idx  <= '0;
          r_addr <= r_base;
        end else begin
          r_idx  <= r_idx + 16'd1;
          r_addr <= w_addr_inc;
        end
        if (r_rd && !cs_n_i) begin
          r_tx_valid <= 1'b1;
          r_tx_data  <= w_tout ? '0 : apb_prdata_i;
        end
        if (w_err) begin
          r_err <= 1'b1;
          if (!r_err) r_err_addr <= r_addr;
        end
      end
    end
  end

  assign w_psel        = (r_state == StSetup) || (r_state == StAccess);
  assign apb_psel_o    = w_psel;
  assign apb_penable_o = (r_state == StAccess);
  assign apb_pwrite_o  = w_psel && !r_rd;
  assign apb_paddr_o   = r_addr;
  assign apb_pwdata_o  = r_pwdata;
  assign apb_pstrb_o   = (w_psel && !r_rd) ? '1 : '0;
  assign apb_pprot_o   = APB_PPROT;
  assign rx_ready_o    = w_rx_ready;
  assign tx_data_o     = r_tx_data;
  assign tx_valid_o    = r_tx_valid;
  assign busy_o        = (r_state != StIdle);
  assign err_o         = r_err;
  assign err_addr_o    = r_err_addr;
  assign xfer_count_o  = r_count;

endmodule

// File: tb/tb_spi_slave_apb4_burst_master.sv
// Self-checking bench: directed burst table, randomized bursts against an address/data model,
// and hand sequences for chip-select abort, asynchronous reset and (if enabled) timeout.
module tb_spi_slave_apb4_burst_master;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cs_n = 1'b1, addr_valid = 1'b0, rd_wr = 1'b0;
  logic [31:0] addr = '0, rx_data = '0, prdata = '0;
  logic [15:0] wrap_length = '0;
  logic        rx_valid = 1'b0, tx_ready = 1'b0, pready = 1'b0, pslverr = 1'b0;
  logic        rx_ready, tx_valid, psel, penable, pwrite, busy, err, tout;
  logic [31:0] tx_data, paddr, pwdata, err_addr;
  logic [3:0]  pstrb;
  logic [2:0]  pprot;
  logic [15:0] xfer_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  spi_slave_apb4_burst_master #(
    .APB_ADDR_WIDTH(32), .APB_DATA_WIDTH(32), .APB_PPROT(3'b000), .TIMEOUT_CYCLES(15)
  ) dut (
    .apb_pclk_i(clk), .apb_preset_ni(rst_n), .cs_n_i(cs_n), .addr_i(addr),
    .addr_valid_i(addr_valid), .rd_wr_i(rd_wr), .wrap_length_i(wrap_length),
    .rx_data_i(rx_data), .rx_valid_i(rx_valid), .rx_ready_o(rx_ready),
    .tx_data_o(tx_data), .tx_valid_o(tx_valid), .tx_ready_i(tx_ready),
    .apb_psel_o(psel), .apb_penable_o(penable), .apb_pwrite_o(pwrite),
    .apb_paddr_o(paddr), .apb_pwdata_o(pwdata), .apb_pstrb_o(pstrb), .apb_pprot_o(pprot),
    .apb_prdata_i(prdata), .apb_pready_i(pready), .apb_pslverr_i(pslverr),
    .busy_o(busy), .err_o(err), .err_addr_o(err_addr), .timeout_o(tout),
    .xfer_count_o(xfer_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Expected address of the k-th transfer of a burst, straight from the wrap rule
  function automatic logic [31:0] model_addr(logic [31:0] base, logic [15:0] wrap, int k);
    if (wrap == 16'd0) return base + 32'(k * 4);
    return base + 32'((k % int'(wrap)) * 4);
  endfunction

  typedef struct {
    logic             rd;
    logic [31:0]      base;
    logic [15:0]      wrap;
    int               n;
    int               err_k;
    logic [5:0][31:0] a;
  } vec_t;

  task automatic run_burst(input logic rd, input logic [31:0] base, input logic [15:0] wrap,
                           input int n, input int err_k, input bit rnd, input bit use_tab,
                           input logic [5:0][31:0] tab);
    logic [31:0] words[$];
    logic [31:0] exp_rd[$];
    logic [31:0] a, exp_eaddr;
    bit          exp_err;
    int          pops, done, pushes, cyc;
    pops = 0; done = 0; pushes = 0; cyc = 0; exp_err = 0; exp_eaddr = '0;
    for (int i = 0; i < n; i++) words.push_back(rnd ? $urandom : 32'hA1 + 32'(i));
    @(negedge clk);
    cs_n = 1'b0; addr_valid = 1'b1; addr = base; rd_wr = rd; wrap_length = wrap;
    rx_valid = 1'b0; tx_ready = 1'b0; pready = 1'b0; pslverr = 1'b0;
    @(negedge clk);
    addr_valid = 1'b0;
    #1;
    chk("arm_busy", 32'(busy), 32'd1);
    chk("arm_err_clear", 32'(err), 32'd0);
    chk("arm_count_clear", 32'(xfer_count), 32'd0);
    while (cyc < 2000) begin
      cs_n       = (done >= n);
      rx_valid   = !rd && (pops < n) && (rnd ? ($urandom_range(0, 3) != 0) : 1'b1);
      rx_data    = (pops < n) ? words[pops] : 32'hDEADBEEF;
      tx_ready   = rd && (done < n) && (rnd ? ($urandom_range(0, 3) != 0) : 1'b1);
      pready     = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      pslverr    = rnd ? ($urandom_range(0, 4) == 0) : (done == err_k);
      prdata     = $urandom;
      addr_valid = rnd && ($urandom_range(0, 7) == 0);
      addr       = $urandom;
      #1;
      if (tx_valid) begin
        if (exp_rd.size() == 0) chk("tx_unexpected", 32'(tx_valid), 32'd0);
        else chk("tx_data", tx_data, exp_rd.pop_front());
        pushes++;
      end
      if (rx_ready && rx_valid) pops++;
      if (psel && penable && pready) begin
        a = model_addr(base, wrap, done);
        chk("paddr", paddr, a);
        if (use_tab) chk("paddr_table", paddr, tab[done]);
        chk("pwrite", 32'(pwrite), 32'(!rd));
        chk("pstrb", 32'(pstrb), rd ? 32'h0 : 32'hF);
        if (!rd) chk("pwdata", pwdata, words[done]);
        if (rd) exp_rd.push_back(prdata);
        if (pslverr && !exp_err) begin
          exp_err   = 1;
          exp_eaddr = a;
        end
        done++;
      end
      if (done >= n && !busy) break;
      @(negedge clk);
      cyc++;
    end
    addr_valid = 1'b0; rx_valid = 1'b0; tx_ready = 1'b0; pready = 1'b0; pslverr = 1'b0;
    if (cyc >= 2000) chk("burst_cycle_budget", 32'(cyc), 32'd0);
    chk("end_idle", 32'(busy), 32'd0);
    chk("end_psel", 32'(psel), 32'd0);
    chk("xfer_count", 32'(xfer_count), 32'(n));
    chk("err_o", 32'(err), 32'(exp_err));
    chk("err_addr", err_addr, exp_eaddr);
    chk("rx_pops", 32'(pops), rd ? 32'd0 : 32'(n));
    chk("tx_pushes", 32'(pushes), rd ? 32'(n) : 32'd0);
    chk("timeout_clear", 32'(tout), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_time_limit actual=expired required=finish");
    $fatal(1, "time limit");
  end

  initial begin
    vec_t vecs[5];
    logic [5:0][31:0] none;
    none = '0;
    vecs[0] = '{1'b0, 32'h1000, 16'd0, 3, -1,
                {32'h0, 32'h0, 32'h0, 32'h1008, 32'h1004, 32'h1000}};
    vecs[1] = '{1'b1, 32'h2008, 16'd4, 6, -1,
                {32'h200C, 32'h2008, 32'h2014, 32'h2010, 32'h200C, 32'h2008}};
    vecs[2] = '{1'b0, 32'h1000, 16'd0, 3, 1,
                {32'h0, 32'h0, 32'h0, 32'h1008, 32'h1004, 32'h1000}};
    vecs[3] = '{1'b0, 32'hFFFFFFF8, 16'd0, 4, -1,
                {32'h0, 32'h0, 32'h4, 32'h0, 32'hFFFFFFFC, 32'hFFFFFFF8}};
    vecs[4] = '{1'b1, 32'h4000, 16'd1, 3, 0,
                {32'h0, 32'h0, 32'h0, 32'h4000, 32'h4000, 32'h4000}};

    // reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst_psel", 32'(psel), 32'd0);
    chk("rst_penable", 32'(penable), 32'd0);
    chk("rst_pwrite", 32'(pwrite), 32'd0);
    chk("rst_pstrb", 32'(pstrb), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("rst_rx_ready", 32'(rx_ready), 32'd0);
    chk("rst_count", 32'(xfer_count), 32'd0);
    chk("pprot", 32'(pprot), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int v = 0; v < 5; v++)
      run_burst(vecs[v].rd, vecs[v].base, vecs[v].wrap, vecs[v].n, vecs[v].err_k, 1'b0, 1'b1,
                vecs[v].a);

    // read stalls in ACCESS while chip select rises: transfer completes, data dropped
    @(negedge clk);
    cs_n = 1'b0; addr_valid = 1'b1; addr = 32'h3000; rd_wr = 1'b1; wrap_length = 16'd0;
    tx_ready = 1'b1; pready = 1'b0;
    @(negedge clk); addr_valid = 1'b0;
    @(negedge clk); tx_ready = 1'b0; #1;
    chk("setup_psel", 32'(psel), 32'd1);
    chk("setup_penable", 32'(penable), 32'd0);
    chk("setup_paddr", paddr, 32'h3000);
    @(negedge clk); #1;
    chk("access_penable", 32'(penable), 32'd1);
    @(negedge clk); cs_n = 1'b1;
    @(negedge clk); #1;
    chk("cs_no_abort", 32'(psel & penable), 32'd1);
    @(negedge clk); pready = 1'b1; prdata = 32'h5555AAAA;
    @(negedge clk); pready = 1'b0; #1;
    chk("cs_done_psel", 32'(psel), 32'd0);
    chk("cs_done_busy", 32'(busy), 32'd0);
    chk("cs_done_tx_valid", 32'(tx_valid), 32'd0);
    chk("cs_done_count", 32'(xfer_count), 32'd1);

    // addr_valid ignored while cs high; ARM falls back to IDLE without popping
    @(negedge clk); cs_n = 1'b1; addr_valid = 1'b1; addr = 32'h8000; rd_wr = 1'b0; rx_valid = 1'b1;
    @(negedge clk); addr_valid = 1'b0; #1;
    chk("idle_cs_high_busy", 32'(busy), 32'd0);
    chk("idle_cs_high_pop", 32'(rx_ready), 32'd0);
    @(negedge clk); cs_n = 1'b0; addr_valid = 1'b1; rx_valid = 1'b0;
    @(negedge clk); addr_valid = 1'b0; cs_n = 1'b1; rx_valid = 1'b1; #1;
    chk("arm_busy_b", 32'(busy), 32'd1);
    chk("arm_cs_high_pop", 32'(rx_ready), 32'd0);
    @(negedge clk); #1;
    chk("arm_abort_idle", 32'(busy), 32'd0);
    rx_valid = 1'b0;

    for (int r = 0; r < 8; r++)
      run_burst(1'($urandom), $urandom & 32'hFFFFFFFC, 16'($urandom_range(0, 5)),
                int'($urandom_range(1, 10)), -1, 1'b1, 1'b0, none);

    // asynchronous reset in the middle of an access
    @(negedge clk);
    cs_n = 1'b0; addr_valid = 1'b1; addr = 32'h5000; rd_wr = 1'b1; tx_ready = 1'b1; pready = 1'b0;
    @(negedge clk); addr_valid = 1'b0;
    @(negedge clk); tx_ready = 1'b0;
    @(negedge clk); #1;
    chk("pre_rst_access", 32'(psel & penable), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_psel", 32'(psel), 32'd0);
    chk("async_rst_penable", 32'(penable), 32'd0);
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_tx_valid", 32'(tx_valid), 32'd0);
    @(negedge clk); rst_n = 1'b1; cs_n = 1'b1;
    run_burst(1'b0, 32'h6000, 16'd2, 5, -1, 1'b0, 1'b0, none);

`ifdef SPI_SLAVE_APB_TIMEOUT_EN
    begin
      int acc;
      acc = 0;
      @(negedge clk);
      cs_n = 1'b0; addr_valid = 1'b1; addr = 32'h7000; rd_wr = 1'b1; wrap_length = 16'd0;
      tx_ready = 1'b1; pready = 1'b0; prdata = 32'hFFFFFFFF;
      @(negedge clk); addr_valid = 1'b0;
      @(negedge clk); tx_ready = 1'b0;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk); #1;
        if (penable) acc++;
        else break;
      end
      chk("timeout_access_cycles", 32'(acc), 32'd15);
      chk("timeout_tx_valid", 32'(tx_valid), 32'd1);
      chk("timeout_tx_zero", tx_data, 32'h0);
      chk("timeout_err", 32'(err), 32'd1);
      chk("timeout_flag", 32'(tout), 32'd1);
      chk("timeout_err_addr", err_addr, 32'h7000);
      cs_n = 1'b1;
      @(negedge clk);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_slave_apb4_burst_master.md
Name: spi_slave_apb4_burst_master

Overview:
- Next-generation APB master plug for the SPI-slave bridge, in the pclk domain between the dual-clock FIFOs / synchroniser and the APB bus.
- Turns one SPI-decoded address plus a stream of words into an incrementing or wrapping APB4 burst: SPI writes become APB writes, SPI reads prefetch APB reads into the TX FIFO.
- Adds APB4 signalling (pstrb, pprot, pslverr), programmable wrap, error capture and a transfer counter.

Parameters:
- APB_ADDR_WIDTH, 32, APB address width.
- APB_DATA_WIDTH, 32, APB data width; legal values 32 or 64. Localparam BYTES = APB_DATA_WIDTH/8.
- APB_PPROT, 3'b000, constant driven on apb_pprot_o.
- TIMEOUT_CYCLES, 255, maximum ACCESS cycles before forced completion (used only with the optional feature).

Ports:
- apb_pclk_i  in  1  APB clock, the only clock.
- apb_preset_ni  in  1  async active-low reset.
- cs_n_i  in  1  synchronised SPI chip select, active low.
- addr_i  in  APB_ADDR_WIDTH  burst base address.
- addr_valid_i  in  1  one-cycle pulse, addr_i/rd_wr_i valid.
- rd_wr_i  in  1  1=read burst, 0=write burst.
- wrap_length_i  in  16  words per wrap window; 0 = linear.
- rx_data_i  in  APB_DATA_WIDTH  write data from RX FIFO.
- rx_valid_i  in  1  RX FIFO valid.
- rx_ready_o  out  1  RX FIFO pop.
- tx_data_o  out  APB_DATA_WIDTH  read data to TX FIFO.
- tx_valid_o  out  1  TX FIFO push.
- tx_ready_i  in  1  TX FIFO has space.
- apb_psel_o, apb_penable_o, apb_pwrite_o  out  1 each  APB control.
- apb_paddr_o  out  APB_ADDR_WIDTH  APB address.
- apb_pwdata_o  out  APB_DATA_WIDTH  APB write data.
- apb_pstrb_o  out  BYTES  all ones on writes, zero on reads.
- apb_pprot_o  out  3  = APB_PPROT.
- apb_prdata_i  in  APB_DATA_WIDTH.
- apb_pready_i, apb_pslverr_i  in  1 each.
- busy_o  out  1  high whenever state != IDLE.
- err_o  out  1  sticky error flag.
- err_addr_o  out  APB_ADDR_WIDTH  address of the first errored transfer.
- timeout_o  out  1  sticky flag: error was a timeout.
- xfer_count_o  out  16  completed transfers in the current burst.

Behaviour:
- Reset: all outputs 0, state IDLE; the reset is asynchronous and may land mid-transfer.
- States:
  - IDLE -> ARM on addr_valid_i while cs_n_i=0. Latches base address, rd_wr and wrap_length; clears err_o, err_addr_o, timeout_o, xfer_count_o; word index 0.
  - ARM (write): wait for rx_valid_i. Then pulse rx_ready_o for 1 cycle, register pwdata and go to SETUP.
  - ARM (read): wait for tx_ready_i, then go to SETUP.
  - ARM -> IDLE if cs_n_i=1.
  - SETUP: psel=1, penable=0, paddr = current address. Always advances to ACCESS next cycle.
  - ACCESS: psel=1, penable=1 until pready_i=1. On completion:
    - drop psel/penable the next cycle;
    - xfer_count_o +1, saturating at 0xFFFF;
    - advance the address;
    - go to ARM if cs_n_i=0, else IDLE.
- Minimum transfer: 2 cycles (SETUP + ACCESS) plus 1 ARM cycle, giving 3 cycles per word at full throughput.
- Read completion: tx_data_o = prdata and tx_valid_o=1 for exactly 1 cycle, only if cs_n_i=0 at completion; otherwise the data is dropped.
- Address advance:
  - wrap_length=0: addr += BYTES, wrapping modulo 2^APB_ADDR_WIDTH.
  - Otherwise the word index increments; when index == wrap_length-1, index returns to 0 and the address returns to the latched base.
- cs_n_i deasserting during SETUP/ACCESS never aborts the APB transfer: it completes normally, then the block goes to IDLE.
- addr_valid_i while not IDLE: ignored.
- pslverr_i=1 with pready_i=1:
  - set err_o;
  - capture err_addr_o only if err_o was 0 (first error wins);
  - the burst continues;
  - read data is still pushed.
- Simultaneous cs deassert and pready: completion is processed first, then IDLE.

Optional Feature:
- Macro: SPI_SLAVE_APB_TIMEOUT_EN.
- When defined:
  - an 8..16-bit counter runs in ACCESS and clears on entry to SETUP;
  - if it reaches TIMEOUT_CYCLES without pready_i, the transfer is force-completed;
  - a forced completion is treated as an error (err_o, err_addr_o, timeout_o=1);
  - a forced read pushes all-zero data under the same cs rule.
- When undefined: no counter, ACCESS waits indefinitely, timeout_o tied 0.

Test Plan:
- Write burst, base 0x1000, wrap 0, pready=1, RX words 0xA1, 0xA2, 0xA3, cs held low -> paddr 0x1000/0x1004/0x1008 with matching pwdata; pstrb=4'hF; 3 rx_ready pulses; xfer_count_o=3.
- Read burst, base 0x2008, wrap_length 4, tx_ready=1, 6 reads -> paddr 0x2008, 0x200C, 0x2010, 0x2014, 0x2008, 0x200C; 6 tx_valid pulses carrying prdata.
- Write burst at 0x1000 with pslverr=1 on the 2nd transfer only -> err_o=1, err_addr_o=0x1004, 3rd transfer still issued; next addr_valid clears err_o.
- Read, pready held low 3 cycles, cs_n_i rises in ACCESS -> transfer completes, no tx_valid, state IDLE, busy_o=0 one cycle after completion.
- Macro defined, TIMEOUT_CYCLES=15, pready stuck low -> psel drops after 15 ACCESS cycles; err_o=1, timeout_o=1, zero data pushed if cs low.
- apb_preset_ni asserted in ACCESS -> psel/penable/tx_valid/busy_o = 0 immediately (asynchronously); after release, a new addr_valid starts a clean burst.
